vram_write_ctrl: RTL and testbench

- Downstream consumer of the MCU bus interface stage: takes its single-cycle command/data strobes, byte data and 32-bit address.
- Turns them into auto-incrementing framebuffer byte writes.
- Writes are buffered in a small FIFO and drained to the VRAM arbiter through a req/ack handshake, so MCU bursts survive arbiter stalls from display readout.

---
 rtl/vram_write_ctrl_pkg.sv | 18 +
 rtl/vram_write_ctrl_sync_fifo.sv | 71 +++++++
 rtl/vram_write_ctrl.sv | 163 ++++++++++++++++
 tb/tb_vram_write_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_write_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// vram_write_ctrl_pkg
// Shared constants for the VRAM write path:
//   - command codes issued by the MCU bus stage (SET_ADDRESS)
//   - drain state machine encodings used by vram_write_ctrl
// ---------------------------------------------------------------------------
package vram_write_ctrl_pkg;

    // Command code that reloads the framebuffer write pointer.
    localparam logic [7:0] CMD_SET_ADDRESS = 8'h02;

    // Drain FSM: IDLE (nothing presented) / REQ (head entry on mem_* bus).
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } drain_state_t;

endpackage

// File: rtl/vram_write_ctrl_sync_fifo.sv
// ---------------------------------------------------------------------------
// vram_write_ctrl_sync_fifo
// Single-clock FIFO, reusable by the readout path.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (pointers/count only)
//   push, din     write request and data; ignored when full unless popping
//   pop           read request; ignored when empty
//   dout          head entry (storage read at rd_ptr, valid while !empty)
//   full, empty   occupancy flags
//   count         occupancy, 0..DEPTH
// DEPTH must be a power of two, >= 2; pointers wrap modulo DEPTH.
// ---------------------------------------------------------------------------
module vram_write_ctrl_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    // A pop frees a slot in the same cycle, so a push into a full FIFO
    // is accepted when it coincides with a pop.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr];

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vram_write_ctrl.sv
// ---------------------------------------------------------------------------
// vram_write_ctrl
// Turns MCU bus-stage command/data strobes into auto-incrementing
// framebuffer byte writes, buffered in a FIFO and drained to the VRAM
// arbiter over a req/ack handshake.
// Ports:
//   sysclk, rst          clock, asynchronous active-high reset
//   cmdclk, dataclk      one-cycle command / data strobes
//   data_in              command code (cmdclk) or pixel byte (dataclk)
//   address_in           SET_ADDRESS target, valid with cmdclk
//   mem_req/addr/data    write request to arbiter, head entry of FIFO
//   mem_ack              arbiter takes the presented write this cycle
//   overflow             sticky, a byte was dropped (cleared by SET_ADDRESS)
//   addr_err             sticky, SET_ADDRESS target >= FB_BYTES
//   busy                 FIFO not empty
//   write_count          completed writes (only with VRAM_WRITE_COUNT_EN)
// Optional feature macro: VRAM_WRITE_COUNT_EN
// ---------------------------------------------------------------------------
module vram_write_ctrl
    import vram_write_ctrl_pkg::*;
#(
    parameter int         ADDR_W          = 19,
    parameter int         FB_BYTES        = 307200,
    parameter int         FIFO_DEPTH      = 16,
    parameter logic [7:0] SET_ADDRESS_CMD = CMD_SET_ADDRESS
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              cmdclk,
    input  logic              dataclk,
    input  logic [7:0]        data_in,
    input  logic [31:0]       address_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    input  logic              mem_ack,
    output logic              overflow,
    output logic              addr_err,
    output logic              busy
`ifdef VRAM_WRITE_COUNT_EN
    ,
    output logic [31:0]       write_count
`endif
);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + 8;

    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  base_ptr;
    logic               set_addr;
    logic               addr_ok;
    logic               pop;
    logic               push_ok;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] head;
    drain_state_t       state;
    drain_state_t       state_nxt;

    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
        return (p == ADDR_W'(FB_BYTES - 1)) ? '0 : p + ADDR_W'(1);
    endfunction

    assign set_addr = cmdclk && (data_in == SET_ADDRESS_CMD);
    assign addr_ok  = (address_in < 32'(FB_BYTES));

    // A reload in the same cycle as a data strobe takes effect first, so
    // the byte lands at the new address.
    always_comb begin
        base_ptr = wr_ptr;
        if (set_addr) begin
            base_ptr = addr_ok ? address_in[ADDR_W-1:0] : '0;
        end
    end

    assign pop     = (state == ST_REQ) && mem_ack;
    assign push_ok = dataclk && (!fifo_full || pop);
    assign busy    = !fifo_empty;

    vram_write_ctrl_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (sysclk),
        .rst   (rst),
        .push  (dataclk),
        .pop   (pop),
        .din   ({base_ptr, data_in}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // The pointer advances even for dropped bytes so later bytes keep
    // their intended addresses.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            overflow <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            wr_ptr <= dataclk ? next_ptr(base_ptr) : base_ptr;
            if (set_addr) begin
                overflow <= 1'b0;
                if (!addr_ok) begin
                    addr_err <= 1'b1;
                end
            end
            if (dataclk && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Entering REQ on the push itself gives mem_req one cycle after the
    // strobe; the head is read from registered FIFO storage.
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty || push_ok) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req  = 1'b1;
                mem_addr = head[ENTRY_W-1:8];
                mem_data = head[7:0];
                if (mem_ack && (fifo_count == CNT_W'(1)) && !push_ok) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef VRAM_WRITE_COUNT_EN
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            write_count <= '0;
        end else if (set_addr) begin
            write_count <= '0;
        end else if (mem_req && mem_ack) begin
            write_count <= write_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vram_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vram_write_ctrl
// Directed bench for vram_write_ctrl with hand-computed expected values.
// Completed writes (mem_req && mem_ack at a clock edge) are logged and
// compared against the expected address/data sequence.
// ---------------------------------------------------------------------------
module tb_vram_write_ctrl;

    logic        sysclk = 1'b0;
    logic        rst;
    logic        cmdclk;
    logic        dataclk;
    logic [7:0]  data_in;
    logic [31:0] address_in;
    logic        mem_req;
    logic [18:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_ack;
    logic        overflow;
    logic        addr_err;
    logic        busy;
`ifdef VRAM_WRITE_COUNT_EN
    logic [31:0] write_count;
`endif

    int total = 0;
    int bad   = 0;

    logic [18:0] log_a [$];
    logic [7:0]  log_d [$];

    vram_write_ctrl dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .cmdclk     (cmdclk),
        .dataclk    (dataclk),
        .data_in    (data_in),
        .address_in (address_in),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_ack    (mem_ack),
        .overflow   (overflow),
        .addr_err   (addr_err),
        .busy       (busy)
`ifdef VRAM_WRITE_COUNT_EN
        ,
        .write_count(write_count)
`endif
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) begin
        if (!rst && mem_req && mem_ack) begin
            log_a.push_back(mem_addr);
            log_d.push_back(mem_data);
        end
    end

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_write(input string tag, input int idx,
                             input logic [18:0] ea, input logic [7:0] ed);
        if (idx < log_a.size()) begin
            chk($sformatf("%s_addr%0d", tag, idx), 32'(log_a[idx]), 32'(ea));
            chk($sformatf("%s_data%0d", tag, idx), 32'(log_d[idx]), 32'(ed));
        end else begin
            chk($sformatf("%s_missing%0d", tag, idx), 32'(log_a.size()), 32'(idx + 1));
        end
    endtask

    task automatic set_addr(input logic [31:0] a);
        cmdclk     = 1'b1;
        data_in    = 8'h02;
        address_in = a;
        step();
        cmdclk     = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] d);
        dataclk = 1'b1;
        data_in = d;
        step();
        dataclk = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
    endtask

    initial begin
        rst        = 1'b1;
        cmdclk     = 1'b0;
        dataclk    = 1'b0;
        data_in    = 8'h00;
        address_in = 32'h0;
        mem_ack    = 1'b0;
        step();
        step();
        chk("rst_req",      32'(mem_req),  32'd0);
        chk("rst_addr",     32'(mem_addr), 32'd0);
        chk("rst_data",     32'(mem_data), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
`ifdef VRAM_WRITE_COUNT_EN
        chk("rst_wcount",   write_count,   32'd0);
`endif
        rst = 1'b0;
        step();

        // Basic burst with ack tied high, one write per cycle.
        mem_ack = 1'b1;
        set_addr(32'h100);
        chk("t1_idle_req", 32'(mem_req), 32'd0);
        dataclk = 1'b1;
        data_in = 8'hAA;
        step();
        chk("t1_lat_req",  32'(mem_req),  32'd1);
        chk("t1_lat_addr", 32'(mem_addr), 32'h100);
        chk("t1_lat_data", 32'(mem_data), 32'hAA);
        data_in = 8'hBB;
        step();
        chk("t1_b_addr", 32'(mem_addr), 32'h101);
        data_in = 8'hCC;
        step();
        chk("t1_c_addr", 32'(mem_addr), 32'h102);
        dataclk = 1'b0;
        step();
        chk("t1_end_req",  32'(mem_req), 32'd0);
        chk("t1_end_busy", 32'(busy),    32'd0);
        chk("t1_count", 32'(log_a.size()), 32'd3);
        chk_write("t1", 0, 19'h100, 8'hAA);
        chk_write("t1", 1, 19'h101, 8'hBB);
        chk_write("t1", 2, 19'h102, 8'hCC);

        // Pointer wrap at the end of the framebuffer.
        clear_log();
        set_addr(32'd307198);
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        wait_idle("t2_idle");
        chk("t2_count", 32'(log_a.size()), 32'd3);
        chk_write("t2", 0, 19'd307198, 8'h11);
        chk_write("t2", 1, 19'd307199, 8'h22);
        chk_write("t2", 2, 19'd0,      8'h33);

        // Arbiter stall: 17 bytes into a 16-deep FIFO, the last is dropped.
        clear_log();
        mem_ack = 1'b0;
        set_addr(32'h0);
        for (int i = 0; i < 17; i++) begin
            push_byte(8'h40 + 8'(i));
        end
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_busy",     32'(busy),     32'd1);
        chk("t3_req",      32'(mem_req),  32'd1);
        step();
        step();
        chk("t3_hold_addr", 32'(mem_addr), 32'h0);
        chk("t3_hold_data", 32'(mem_data), 32'h40);
        chk("t3_no_writes", 32'(log_a.size()), 32'd0);
        mem_ack = 1'b1;
        wait_idle("t3_idle");
        chk("t3_count", 32'(log_a.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk_write("t3", i, 19'(i), 8'h40 + 8'(i));
        end
        clear_log();
        push_byte(8'h77);
        wait_idle("t3b_idle");
        chk_write("t3b", 0, 19'h11, 8'h77);
        chk("t3_overflow_sticky", 32'(overflow), 32'd1);

        // Out-of-range SET_ADDRESS: pointer to 0, addr_err, overflow cleared.
        clear_log();
        set_addr(32'h0010_0000);
        chk("t4_addr_err", 32'(addr_err), 32'd1);
        chk("t4_overflow", 32'(overflow), 32'd0);
        push_byte(8'h99);
        wait_idle("t4_idle");
        chk_write("t4", 0, 19'h0, 8'h99);

        // Reset with queued writes: mem_req drops at once, queue discarded.
        clear_log();
        mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_byte(8'hE0 + 8'(i));
        end
        chk("t5_pre_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_async_req",  32'(mem_req),  32'd0);
        chk("t5_async_busy", 32'(busy),     32'd0);
        chk("t5_async_addr", 32'(mem_addr), 32'd0);
        mem_ack = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        step();
        step();
        chk("t5_post_req",  32'(mem_req),  32'd0);
        chk("t5_post_busy", 32'(busy),     32'd0);
        chk("t5_post_err",  32'(addr_err), 32'd0);
        chk("t5_no_writes", 32'(log_a.size()), 32'd0);

        // Command and data strobe in the same cycle. data_in is one shared
        // bus, so the byte written alongside SET_ADDRESS is the code 02.
        clear_log();
        cmdclk     = 1'b1;
        dataclk    = 1'b1;
        data_in    = 8'h02;
        address_in = 32'h40;
        step();
        cmdclk  = 1'b0;
        dataclk = 1'b0;
        push_byte(8'h5A);
        wait_idle("t6_idle");
        chk("t6_count", 32'(log_a.size()), 32'd2);
        chk_write("t6", 0, 19'h40, 8'h02);
        chk_write("t6", 1, 19'h41, 8'h5A);
`ifdef VRAM_WRITE_COUNT_EN
        chk("t6_wcount", write_count, 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
